ex_muldiv: RTL and testbench
============================

// Module: ex_muldiv
// PURPOSE
//  Iterative RV32M multiply/divide unit in the EX stage, directly upstream of the register file write port.
//  Takes rs1/rs2 operands read by ID and the destination index.
//  Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over 32 iterations.
//  Drives the register file write port (waddr/wdata/wen) for one cycle, and holds busy_o to stall the pipeline meanwhile.
// PARAMETERS
//  XLEN  32  operand/result width; only 32 is supported (counter and encodings are sized for it)
// PORTS
//  clk          in   1     clock; all state updates on the rising edge
//  rst          in   1     reset, asynchronous, active-low; one clock domain
//  start_i      in   1     issue request for an M-extension op
//  op_i         in   3     funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  rs1_data_i   in   32    operand A (dividend / multiplicand)
//  rs2_data_i   in   32    operand B (divisor / multiplier)
//  rd_addr_i    in   5     destination register index
//  flush_i      in   1     kill the in-flight op (branch/exception redirect)
//  busy_o       out  1     high whenever state != IDLE; upstream holds the instruction and stalls
//  done_o       out  1     one-cycle pulse when the result is valid
//  reg_waddr_o  out  5     write index to the register file
//  reg_wdata_o  out  32    write data to the register file
//  reg_wen_o    out  1     write enable; equals done_o && (reg_waddr_o != 0)
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, cnt=0, all outputs 0, internal accumulators 0. Reset mid-operation discards the op, with no write.
//  - FSM states: IDLE, CALC, DONE.
//  - IDLE: if start_i && !flush_i at an edge, latch op, rd, operands and signs.
//    - Fast path (div/rem with rs2==0, or signed overflow 0x80000000 / -1) -> DONE.
//    - Otherwise -> CALC with cnt=0.
//  - CALC: one iteration per edge; cnt counts 0..31. After the edge with cnt==31 -> DONE with the result registered.
//  - DONE: lasts exactly one cycle; done_o=1, outputs valid, and reg_wen_o follows the rule above. Next edge -> IDLE.
//  - Outputs are registered. reg_waddr_o and reg_wdata_o hold their last value in IDLE; done_o and reg_wen_o are 0 outside DONE.
//  - Latency, counting edges after the accept edge E0:
//    - normal op: DONE visible after E32 (33 edges total);
//    - fast path: DONE visible after E0.
//    busy_o is high from after E0 through the DONE cycle.
//  - Back-to-back: start_i in the DONE cycle is ignored; re-issue is accepted only in IDLE.
//  - start_i while busy_o=1 is ignored; upstream must hold it.
//  - flush_i:
//    - in CALC -> IDLE on the next edge, with no done and no write;
//    - same cycle as start_i in IDLE -> not accepted;
//    - in DONE -> no effect (the write already committed).
//  - Multiply: unsigned shift-add on |A| and |B|, producing a 64-bit product, then negated if the result sign is negative.
//    - MUL: signed x signed, low 32 bits.
//    - MULH: signed x signed, high 32 bits.
//    - MULHSU: A signed, B unsigned; sign = sA.
//    - MULHU: unsigned, high 32 bits.
//  - Divide: restoring algorithm on magnitudes. Quotient sign = sA^sB; remainder sign = sA (signed ops only).
//  - Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1.
//  - Overflow, DIV 0x80000000 / 0xFFFFFFFF: DIV -> 0x80000000, REM -> 0.
//  - Operands are latched at accept, so later changes on rs*_data_i have no effect.
// STRUCTURE
//  - Package muldiv_pkg: funct3 op constants (OP_MUL..OP_REMU), state encodings (S_IDLE/S_CALC/S_DONE), XLEN.
//  - Single module with no sub-module. Datapath: one 33-bit add/sub, 64-bit shift register (acc:quotient / product), 5-bit cnt.
// TESTING
//  1. MUL 7 * -3 (rs2=0xFFFFFFFD), rd=5 -> after 33 edges: done=1, wen=1, waddr=5, wdata=0xFFFFFFEB. busy high throughout.
//  2. MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU -1*0xFFFFFFFF -> 0xFFFFFFFF.
//  3. DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
//  4. Fast path, each with done after E0:
//     - DIV 5/0 -> 0xFFFFFFFF;
//     - REMU 5/0 -> 5;
//     - DIV 0x80000000/-1 -> 0x80000000;
//     - REM of the same -> 0.
//  5. flush_i asserted at cnt=10 -> IDLE next edge, no done/wen. New start next cycle completes correctly.
//  6. Reset:
//     - rst low mid-CALC -> outputs 0 immediately (async), no write.
//     - rd=0 op -> done=1, wen=0.
//     - start_i while busy -> ignored.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M iterative multiply/divide unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package muldiv_pkg;

  localparam int XLEN = 32;

  // funct3 encodings of the M extension
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // funct3[2] separates the divide family from the multiply family
  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide feeding the register-file write port.
// Latency: 33 edges from accept to DONE (32 iterations + result), 1 edge for div-by-zero/overflow.
// Backpressure: busy_o holds the pipeline; start_i is only accepted in IDLE and flush_i kills CALC.
// Ports: clk/rst (async active-low); start_i, op_i, rs1_data_i, rs2_data_i, rd_addr_i issue an op;
//        flush_i aborts it; busy_o, done_o and reg_waddr_o/reg_wdata_o/reg_wen_o report the result.
module ex_muldiv #(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [4:0]      reg_waddr_o,
  output logic [XLEN-1:0] reg_wdata_o,
  output logic            reg_wen_o
);
  import muldiv_pkg::*;

  state_t          state;
  logic [4:0]      cnt;
  logic [2:0]      op_q;
  logic [4:0]      rd_q;
  logic            neg_q;    // sign to apply to product / quotient
  logic            neg_r_q;  // sign to apply to remainder
  logic [XLEN-1:0] acc;      // upper product half / partial remainder
  logic [XLEN-1:0] lo;       // multiplier shifting out / dividend shifting out, quotient shifting in
  logic [XLEN-1:0] opb;      // multiplicand / divisor magnitude

  // ---------------- accept-time decode ----------------
  logic            a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] fast_res;

  assign a_signed = (op_i != OP_MULHU) && (op_i != OP_DIVU) && (op_i != OP_REMU);
  assign b_signed = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
  assign sa       = a_signed & rs1_data_i[XLEN-1];
  assign sb       = b_signed & rs2_data_i[XLEN-1];
  assign mag_a    = sa ? (~rs1_data_i + 1'b1) : rs1_data_i;
  assign mag_b    = sb ? (~rs2_data_i + 1'b1) : rs2_data_i;

  assign div_zero = op_is_div(op_i) && (rs2_data_i == '0);
  assign div_ovf  = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                    (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data_i == '1);

  always_comb begin
    fast_res = '0;
    if (div_zero)
      fast_res = op_i[1] ? rs1_data_i : '1;              // REM/REMU -> dividend, DIV/DIVU -> all ones
    else if (div_ovf)
      fast_res = op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // ---------------- shared iteration datapath ----------------
  logic            is_div;
  logic [XLEN:0]   shifted, add_a, add_b, sum;
  logic            borrow;
  logic [XLEN-1:0] acc_nx, lo_nx;

  assign is_div  = op_is_div(op_q);
  assign shifted = {acc, lo[XLEN-1]};
  assign add_a   = is_div ? shifted : {1'b0, acc};
  assign add_b   = {1'b0, opb};
  // One 33-bit adder: add for multiply, subtract (two's complement) for divide.
  assign sum     = add_a + (add_b ^ {(XLEN+1){is_div}}) + {{XLEN{1'b0}}, is_div};
  // Since acc < divisor, the 33-bit difference's top bit is exactly the borrow.
  assign borrow  = sum[XLEN];

  always_comb begin
    acc_nx = acc;
    lo_nx  = lo;
    if (is_div) begin
      acc_nx = borrow ? shifted[XLEN-1:0] : sum[XLEN-1:0];
      lo_nx  = {lo[XLEN-2:0], ~borrow};
    end else if (lo[0]) begin
      acc_nx = sum[XLEN:1];
      lo_nx  = {sum[0], lo[XLEN-1:1]};
    end else begin
      acc_nx = {1'b0, acc[XLEN-1:1]};
      lo_nx  = {acc[0], lo[XLEN-1:1]};
    end
  end

  // ---------------- final sign fix-up and selection ----------------
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quot, remd, calc_res;

  assign prod   = {acc_nx, lo_nx};
  assign prod_s = neg_q ? (~prod + 1'b1) : prod;
  assign quot   = neg_q ? (~lo_nx + 1'b1) : lo_nx;
  assign remd   = neg_r_q ? (~acc_nx + 1'b1) : acc_nx;

  always_comb begin
    calc_res = '0;
    case (op_q)
      OP_MUL:                      calc_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: calc_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             calc_res = quot;
      default:                     calc_res = remd;
    endcase
  end

  assign busy_o = (state != S_IDLE);

  // ---------------- control ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op_q        <= '0;
      rd_q        <= '0;
      neg_q       <= 1'b0;
      neg_r_q     <= 1'b0;
      acc         <= '0;
      lo          <= '0;
      opb         <= '0;
      done_o      <= 1'b0;
      reg_wen_o   <= 1'b0;
      reg_waddr_o <= '0;
      reg_wdata_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i && !flush_i) begin
            op_q    <= op_i;
            rd_q    <= rd_addr_i;
            neg_q   <= sa ^ sb;
            neg_r_q <= sa;
            if (div_zero || div_ovf) begin
              state       <= S_DONE;
              done_o      <= 1'b1;
              reg_waddr_o <= rd_addr_i;
              reg_wdata_o <= fast_res;
              reg_wen_o   <= (rd_addr_i != 5'd0);
            end else begin
              state <= S_CALC;
              cnt   <= '0;
              acc   <= '0;
              // multiply: lo = multiplier, opb = multiplicand; divide: lo = dividend, opb = divisor
              lo    <= op_is_div(op_i) ? mag_a : mag_b;
              opb   <= op_is_div(op_i) ? mag_b : mag_a;
            end
          end
        end
        S_CALC: begin
          if (flush_i) begin
            state <= S_IDLE;
          end else begin
            acc <= acc_nx;
            lo  <= lo_nx;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state       <= S_DONE;
              done_o      <= 1'b1;
              reg_waddr_o <= rd_q;
              reg_wdata_o <= calc_res;
              reg_wen_o   <= (rd_q != 5'd0);
            end
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          done_o    <= 1'b0;
          reg_wen_o <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed RV32M cases plus a random issue/flush stream.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        flush_i = 1'b0;
  logic        busy_o, done_o, reg_wen_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;

  ex_muldiv dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .rd_addr_i(rd_addr_i),
    .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o),
    .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o), .reg_wen_o(reg_wen_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ubs;
    logic [63:0] ua, ub, p;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ubs = ub;
    p   = '0;
    case (op)
      3'd0: begin p = sa * sb;  return p[31:0];  end
      3'd1: begin p = sa * sb;  return p[63:32]; end
      3'd2: begin p = sa * ubs; return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic bit ref_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 0) || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  // Model: an accepted op is "active"; m_k counts edges left until the result is visible.
  bit          m_active = 0;
  int          m_k = 0;
  logic [4:0]  m_rd = '0, m_waddr = '0;
  logic [31:0] m_res = '0, m_wdata = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 0; m_k = 0; m_waddr = '0; m_wdata = '0;
    end else if (m_active) begin
      if (m_k == 0) m_active = 0;
      else if (flush_i) m_active = 0;
      else begin
        m_k--;
        if (m_k == 0) begin m_waddr = m_rd; m_wdata = m_res; end
      end
    end else if (start_i && !flush_i) begin
      m_active = 1;
      m_rd     = rd_addr_i;
      m_res    = ref_res(op_i, rs1_data_i, rs2_data_i);
      m_k      = ref_fast(op_i, rs1_data_i, rs2_data_i) ? 0 : 32;
      if (m_k == 0) begin m_waddr = m_rd; m_wdata = m_res; end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("busy",  busy_o,      m_active);
    chk("done",  done_o,      m_active && m_k == 0);
    chk("wen",   reg_wen_o,   m_active && m_k == 0 && m_rd != 0);
    chk("waddr", reg_waddr_o, m_waddr);
    chk("wdata", reg_wdata_o, m_wdata);
  end

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Issue one op at a negedge and check its result against a literal; a stray start is poked mid-op.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] expv, input int lat);
    int n;
    n = 0;
    while (m_active && n < 100) begin @(negedge clk); n++; end
    start_i = 1'b1; flush_i = 1'b0; op_i = op; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd;
    @(negedge clk);
    start_i = 1'b0; rs1_data_i = $urandom; rs2_data_i = $urandom; rd_addr_i = $urandom;
    n = 0;
    while (!done_o && n < 60) begin
      start_i = (n == 3);
      if (n == 3) begin op_i = $urandom; rs1_data_i = $urandom; rs2_data_i = $urandom; end
      @(negedge clk);
      n++;
    end
    start_i = 1'b0;
    chk("latency",   n, lat);
    chk("result",    reg_wdata_o, expv);
    chk("res_waddr", reg_waddr_o, rd);
    chk("res_wen",   reg_wen_o, rd != 0);
  endtask

  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_wen",  reg_wen_o, 0);
    chk("rst_waddr", reg_waddr_o, 0);
    chk("rst_wdata", reg_wdata_o, 0);
    rst = 1'b1;
    @(negedge clk);

    run_op(3'd0, 32'd7,        32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 32);
    run_op(3'd1, 32'h80000000, 32'h80000000, 5'd1, 32'h40000000, 32);
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 32);
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF, 32);
    run_op(3'd4, 32'hFFFFFFF9, 32'd2,        5'd4, 32'hFFFFFFFD, 32);
    run_op(3'd6, 32'hFFFFFFF9, 32'd2,        5'd6, 32'hFFFFFFFF, 32);
    run_op(3'd5, 32'd100,      32'd7,        5'd7, 32'd14,       32);
    run_op(3'd7, 32'd100,      32'd7,        5'd8, 32'd2,        32);
    run_op(3'd4, 32'd5,        32'd0,        5'd9, 32'hFFFFFFFF, 0);
    run_op(3'd7, 32'd5,        32'd0,        5'd10, 32'd5,       0);
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 0);
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,       0);
    run_op(3'd0, 32'd3,        32'd4,        5'd0, 32'd12,       32);

    // Flush at cnt==10, then a fresh op must complete normally.
    start_i = 1'b1; op_i = 3'd5; rs1_data_i = 32'd1000; rs2_data_i = 32'd3; rd_addr_i = 5'd13;
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_busy", busy_o, 0);
    chk("flush_done", done_o, 0);
    run_op(3'd5, 32'd1000, 32'd3, 5'd14, 32'd333, 32);

    // Asynchronous reset in the middle of CALC.
    start_i = 1'b1; op_i = 3'd0; rs1_data_i = 32'd9; rs2_data_i = 32'd9; rd_addr_i = 5'd15;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_done", done_o, 0);
    chk("arst_wen",  reg_wen_o, 0);
    chk("arst_waddr", reg_waddr_o, 0);
    chk("arst_wdata", reg_wdata_o, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Random stream: starts in every state, occasional flushes, changing operands.
    for (int c = 0; c < 4000; c++) begin
      start_i    = ($urandom_range(0, 3) == 0);
      flush_i    = ($urandom_range(0, 49) == 0);
      op_i       = $urandom;
      rs1_data_i = rnd32();
      rs2_data_i = rnd32();
      rd_addr_i  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      @(negedge clk);
    end
    start_i = 1'b0;
    flush_i = 1'b0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
